// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_XFER = 1'b1
   } state_e;

   localparam int N_REQ_MAX = 8;
   localparam int CNT_W     = 16;
   localparam int IDX_W     = $clog2(N_REQ_MAX);

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: searches upward from the slot after last_i,
// wrapping at N_REQ-1 -> 0, and returns the first requester as one-hot.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N_REQ-1:0] win_o
);

   always_comb begin
      int   idx;
      logic found;
      win_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_i) + k) % N_REQ;
         if (!found && req_i[idx]) begin
            win_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding N_REQ byte streams into one UART TX FIFO.
// Optional idle-timeout grant release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   input  logic               tx_full,
   output logic               tx_write,
   output logic [7:0]         tx_data,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               timeout_pulse
);

   if (N_REQ < 2 || N_REQ > N_REQ_MAX || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("uart_tx_arbiter: N_REQ or TIMEOUT out of range");
   end

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [N_REQ-1:0]   win;
   logic [IDX_W-1:0]   g_idx;
   logic [7:0]         g_data;
   logic               g_valid, g_last;

   uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i  (req_valid),
      .last_i (last_q),
      .win_o  (win)
   );

   // grant_q is zero outside XFER, so masking with it also gates on state.
   always_comb begin
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            g_idx  = IDX_W'(i);
            g_data = req_data[8*i +: 8];
         end
      end
      busy      = (state_q == S_XFER);
      g_valid   = |(req_valid & grant_q);
      g_last    = |(req_last & grant_q);
      tx_write  = busy & g_valid & ~tx_full;
      tx_data   = tx_write ? g_data : 8'h00;
      req_ready = (busy && !tx_full) ? grant_q : '0;
      grant     = grant_q;
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (|req_valid) begin
               grant_d = win;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (tx_write && g_last) begin
               state_d = S_IDLE;
               grant_d = '0;
               last_d  = g_idx;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (tx_write) begin
               cnt_d = '0;
            end else if (!g_valid && !tx_full) begin
               // This is the TIMEOUT-th idle cycle: release on this edge.
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_d = S_IDLE;
                  grant_d = '0;
                  last_d  = g_idx;
                  cnt_d   = '0;
                  to_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout_pulse = to_q;
`else
   assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=255); covers both
// UART_ARB_TIMEOUT_EN builds.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_full;
   logic        tx_write;
   logic [7:0]  tx_data;
   logic [3:0]  grant;
   logic        busy;
   logic        timeout_pulse;

   int compared   = 0;
   int mismatched = 0;
   int wr_cnt     = 0;
   int pulse_cnt  = 0;

   uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(255)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_full       (tx_full),
      .tx_write      (tx_write),
      .tx_data       (tx_data),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_write) wr_cnt <= wr_cnt + 1;
      if (timeout_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[8*i +: 8] = v;
   endtask

   initial begin
      int order [5];
      int base;
      order = '{0, 1, 2, 3, 0};

      reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
      #2;
      chk("rst_grant", grant, 0);
      chk("rst_tx_write", tx_write, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_pulse, 0);
      step();
      reset = 1'b0;

      // Three-byte packet from requester 0
      req_valid = 4'b0001; set_data(0, 8'h41); #1;
      chk("t1_idle_write", tx_write, 0);
      chk("t1_idle_busy", busy, 0);
      step();
      chk("t1_grant", grant, 4'b0001);
      chk("t1_ready", req_ready, 4'b0001);
      chk("t1_busy", busy, 1);
      chk("t1_w0", tx_write, 1);
      chk("t1_d0", tx_data, 8'h41);
      step(); set_data(0, 8'h42); #1;
      chk("t1_w1", tx_write, 1);
      chk("t1_d1", tx_data, 8'h42);
      step(); set_data(0, 8'h43); req_last = 4'b0001; #1;
      chk("t1_w2", tx_write, 1);
      chk("t1_d2", tx_data, 8'h43);
      step(); req_valid = '0; req_last = '0; #1;
      chk("t1_end_grant", grant, 0);
      chk("t1_end_busy", busy, 0);
      chk("t1_end_write", tx_write, 0);

      // All requesters valid with single-byte packets, fresh priority
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 4'b1111; req_last = 4'b1111;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
      #1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t2_grant", grant, 32'(1) << order[k]);
         chk("t2_data", tx_data, 32'(8'h10 + order[k]));
         step();
         if (k == 4) begin
            req_valid = '0; req_last = '0;
         end
         #1;
         chk("t2_bubble_grant", grant, 0);
         chk("t2_bubble_write", tx_write, 0);
      end

      // tx_full stall mid-packet on requester 2
      base = wr_cnt;
      req_valid = 4'b0100; set_data(2, 8'h60); #1;
      step();
      chk("t3_grant", grant, 4'b0100);
      chk("t3_d0", tx_data, 8'h60);
      step(); set_data(2, 8'h61); tx_full = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk("t3_stall_write", tx_write, 0);
         chk("t3_stall_ready", req_ready, 0);
         chk("t3_stall_grant", grant, 4'b0100);
         step();
      end
      tx_full = 1'b0; #1;
      chk("t3_d1_write", tx_write, 1);
      chk("t3_d1", tx_data, 8'h61);
      step(); set_data(2, 8'h62); req_last = 4'b0100; #1;
      chk("t3_d2", tx_data, 8'h62);
      step(); req_valid = '0; req_last = '0; #1;
      chk("t3_end_busy", busy, 0);
      chk("t3_byte_count", wr_cnt - base, 3);

      // Requester 1 goes silent mid-packet while requester 2 waits
      base = pulse_cnt;
      req_valid = 4'b0010; set_data(1, 8'h70); set_data(2, 8'h80); #1;
      step();
      chk("t4_grant", grant, 4'b0010);
      chk("t4_d0", tx_data, 8'h70);
      step(); req_valid = 4'b0100;
      for (int i = 1; i <= 300; i++) begin
         #1;
         if (i == 1) begin
            chk("t4_hold_grant", grant, 4'b0010);
            chk("t4_hold_write", tx_write, 0);
         end
`ifdef UART_ARB_TIMEOUT_EN
         if (i == 255) begin
            chk("t4_pre_grant", grant, 4'b0010);
            chk("t4_pre_pulse", timeout_pulse, 0);
         end
         if (i == 256) begin
            chk("t4_pulse", timeout_pulse, 1);
            chk("t4_release_grant", grant, 0);
         end
         if (i == 257) chk("t4_next_grant", grant, 4'b0100);
`endif
         step();
      end
`ifdef UART_ARB_TIMEOUT_EN
      chk("t4_pulse_count", pulse_cnt - base, 1);
`else
      chk("t4_held_grant", grant, 4'b0010);
      chk("t4_pulse_count", pulse_cnt - base, 0);
`endif
      req_valid = '0;

      // Reset during byte 2 of a 4-byte packet
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 4'b0100; set_data(2, 8'h90); #1;
      step();
      chk("t5_grant", grant, 4'b0100);
      chk("t5_d0", tx_data, 8'h90);
      step(); set_data(2, 8'h91); #1;
      chk("t5_d1_write", tx_write, 1);
      reset = 1'b1; #1;
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_write", tx_write, 0);
      chk("t5_rst_data", tx_data, 0);
      chk("t5_rst_ready", req_ready, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_timeout", timeout_pulse, 0);
      step();
      reset = 1'b0; req_valid = 4'b0101; #1;
      chk("t5_idle_grant", grant, 0);
      step();
      chk("t5_first_winner", grant, 4'b0001);
      req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
